// File: rtl/skid_reg16.sv
// Two-entry skid register between an upstream producer and the NOT/ALU stage.
// Define SKID_REG16_INVERT_EN to present the bitwise inverse of the main register on out_data.
module skid_reg16 #(
    parameter int WIDTH = 16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             flush,
    input  logic [WIDTH-1:0] in_data,
    input  logic             in_valid,
    output logic             in_ready,
    output logic [WIDTH-1:0] out_data,
    output logic             out_valid,
    input  logic             out_ready
);

    typedef enum logic [1:0] {
        EMPTY = 2'd0,
        BUSY  = 2'd1,
        FULL  = 2'd2
    } state_e;

    state_e           state_q, state_d;
    logic [WIDTH-1:0] main_q, main_d;
    logic [WIDTH-1:0] skid_q, skid_d;
    logic             out_valid_q, out_valid_d;
    logic             in_ready_q, in_ready_d;
    logic             in_xfer;
    logic             out_xfer;

    // Handshakes use the registered flags, so out_ready never reaches in_ready combinationally.
    assign in_xfer  = in_valid && in_ready_q;
    assign out_xfer = out_valid_q && out_ready;

    always_comb begin
        state_d = state_q;
        main_d  = main_q;
        skid_d  = skid_q;

        unique case (state_q)
            EMPTY: begin
                if (in_xfer) begin
                    main_d  = in_data;
                    state_d = BUSY;
                end
            end
            BUSY: begin
                if (in_xfer && out_xfer) begin
                    main_d = in_data;
                end else if (in_xfer) begin
                    skid_d  = in_data;
                    state_d = FULL;
                end else if (out_xfer) begin
                    state_d = EMPTY;
                end
            end
            FULL: begin
                if (out_xfer) begin
                    main_d  = skid_q;
                    state_d = BUSY;
                end
            end
            default: state_d = EMPTY;
        endcase

        // Flush wins over any transfer on this edge; stored words stay but are no longer valid.
        if (flush) begin
            state_d = EMPTY;
            main_d  = main_q;
            skid_d  = skid_q;
        end

        out_valid_d = (state_d != EMPTY);
        in_ready_d  = (state_d != FULL);
    end

    // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q     <= EMPTY;
            main_q      <= '0;
            skid_q      <= '0;
            out_valid_q <= 1'b0;
            in_ready_q  <= 1'b1;
        end else begin
            state_q     <= state_d;
            main_q      <= main_d;
            skid_q      <= skid_d;
            out_valid_q <= out_valid_d;
            in_ready_q  <= in_ready_d;
        end
    end

    assign out_valid = out_valid_q;
    assign in_ready  = in_ready_q;

`ifdef SKID_REG16_INVERT_EN
    assign out_data = ~main_q;
`else
    assign out_data = main_q;
`endif

endmodule

// File: tb/tb_skid_reg16.sv
// Scoreboard bench for skid_reg16: words are queued on accept and compared on every output cycle.
module tb_skid_reg16;

    logic        clk;
    logic        rst;
    logic        flush;
    logic [15:0] in_data;
    logic        in_valid;
    logic        in_ready;
    logic [15:0] out_data;
    logic        out_valid;
    logic        out_ready;

    int          total;
    int          bad;
    logic [15:0] sb[$];

    skid_reg16 #(.WIDTH(16)) dut (
        .clk       (clk),
        .rst       (rst),
        .flush     (flush),
        .in_data   (in_data),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .out_data  (out_data),
        .out_valid (out_valid),
        .out_ready (out_ready)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic logic [15:0] exp_out(input logic [15:0] w);
`ifdef SKID_REG16_INVERT_EN
        return ~w;
`else
        return w;
`endif
    endfunction

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s: got=%h expected=%h at %0t", tag, got, exp, $time);
        end
    endtask

    // One cycle: drive at negedge, check just before the posedge, then advance the model.
    task automatic step(input logic iv, input logic [15:0] id, input logic ordy, input logic fl);
        logic do_push;
        logic do_pop;
        in_valid  = iv;
        in_data   = id;
        out_ready = ordy;
        flush     = fl;
        #4;
        check("out_valid", out_valid, sb.size() != 0);
        check("in_ready", in_ready, sb.size() < 2);
        if (sb.size() != 0) check("out_data", out_data, exp_out(sb[0]));
        do_pop  = (sb.size() != 0) && ordy;
        do_push = iv && (sb.size() < 2);
        @(posedge clk);
        if (fl) begin
            sb.delete();
        end else begin
            if (do_pop) void'(sb.pop_front());
            if (do_push) sb.push_back(id);
        end
        @(negedge clk);
    endtask

    initial begin
        total     = 0;
        bad       = 0;
        rst       = 1'b1;
        flush     = 1'b0;
        in_data   = '0;
        in_valid  = 1'b0;
        out_ready = 1'b0;
        #2;
        check("rst_valid", out_valid, 1'b0);
        check("rst_ready", in_ready, 1'b1);
        check("rst_data", out_data, exp_out(16'h0000));
        @(negedge clk);
        rst = 1'b0;

        // Single word with one-cycle latency.
        step(1'b1, 16'h1234, 1'b1, 1'b0);
        check("single_valid", out_valid, 1'b1);
        check("single_data", out_data, exp_out(16'h1234));
        step(1'b0, 16'h0000, 1'b1, 1'b0);
        check("single_gone", out_valid, 1'b0);

        // Backpressure fills main and skid, then drains in order.
        step(1'b1, 16'hA5A5, 1'b0, 1'b0);
        step(1'b1, 16'h5A5A, 1'b0, 1'b0);
        check("bp_full", in_ready, 1'b0);
        for (int i = 0; i < 3; i++) step(1'b1, 16'hDEAD, 1'b0, 1'b0);
        check("bp_stable", out_data, exp_out(16'hA5A5));
        step(1'b0, 16'h0000, 1'b1, 1'b0);
        check("bp_ready_back", in_ready, 1'b1);
        check("bp_second", out_data, exp_out(16'h5A5A));
        step(1'b0, 16'h0000, 1'b1, 1'b0);
        step(1'b0, 16'h0000, 1'b1, 1'b0);

        // Streaming 0..99: valid every cycle once the first word lands.
        for (int i = 0; i < 100; i++) step(1'b1, 16'(i), 1'b1, 1'b0);
        step(1'b0, 16'h0000, 1'b1, 1'b0);
        step(1'b0, 16'h0000, 1'b1, 1'b0);

        // Flush while FULL, with a word offered on the same edge.
        step(1'b1, 16'h0001, 1'b0, 1'b0);
        step(1'b1, 16'h0002, 1'b0, 1'b0);
        step(1'b1, 16'h0003, 1'b0, 1'b1);
        check("flush_valid", out_valid, 1'b0);
        check("flush_ready", in_ready, 1'b1);
        for (int i = 0; i < 3; i++) step(1'b0, 16'h0000, 1'b1, 1'b0);

        // Asynchronous reset pulse between edges while FULL.
        step(1'b1, 16'h0007, 1'b0, 1'b0);
        step(1'b1, 16'h0008, 1'b0, 1'b0);
        in_valid = 1'b0;
        #2;
        rst = 1'b1;
        #1;
        check("arst_valid", out_valid, 1'b0);
        check("arst_ready", in_ready, 1'b1);
        check("arst_data", out_data, exp_out(16'h0000));
        #1;
        rst = 1'b0;
        sb.delete();
        @(negedge clk);
        step(1'b1, 16'h0009, 1'b1, 1'b0);
        step(1'b0, 16'h0000, 1'b1, 1'b0);

        // Inversion pattern (plain pass-through in the default build).
        step(1'b1, 16'h00FF, 1'b0, 1'b0);
        check("invert_data", out_data, exp_out(16'h00FF));
        step(1'b0, 16'h0000, 1'b1, 1'b0);

        // Random traffic with occasional flush.
        for (int i = 0; i < 300; i++)
            step(1'($urandom_range(0, 1)), 16'($urandom),
                 1'($urandom_range(0, 1)), ($urandom_range(0, 19) == 0));
        for (int i = 0; i < 3; i++) step(1'b0, 16'h0000, 1'b1, 1'b0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/skid_reg16.md
SKID_REG16 -- requirements
Module: skid_reg16

Interface
REQ-001 SHALL have parameter: WIDTH, 16, data word width in bits.
REQ-002 SHALL have port: clk  input  1  rising-edge clock; the only clock.
REQ-003 SHALL have port: rst  input  1  asynchronous, active-high reset.
REQ-004 SHALL have port: flush  input  1  synchronous discard of all held words.
REQ-005 SHALL have port: in_data  input  WIDTH  upstream word.
REQ-006 SHALL have port: in_valid  input  1  upstream word present.
REQ-007 SHALL have port: in_ready  output  1  block can accept a word this cycle.
REQ-008 SHALL have port: out_data  output  WIDTH  word presented downstream (to the bitwise-NOT/ALU stage).
REQ-009 SHALL have port: out_valid  output  1  out_data holds a valid word.
REQ-010 SHALL have port: out_ready  input  1  downstream accepts out_data this cycle.

Function
REQ-011 SHALL complete an input transfer on a clk edge where in_valid=1 and in_ready=1, and an output transfer where out_valid=1 and out_ready=1.
REQ-012 SHALL hold two registers: main (drives out_data) and skid (overflow), plus an FSM with states EMPTY, BUSY and FULL.
REQ-013 SHALL drive outputs from state only: EMPTY gives out_valid=0, in_ready=1; BUSY gives out_valid=1, in_ready=1; FULL gives out_valid=1, in_ready=0. There SHALL be no combinational path from out_ready to in_ready.
REQ-014 EMPTY: on input transfer, main<=in_data and go to BUSY; otherwise stay.
REQ-015 BUSY, input and output transfer together: main<=in_data and stay BUSY.
REQ-016 BUSY, input transfer only: skid<=in_data and go to FULL.
REQ-017 BUSY, output transfer only: go to EMPTY.
REQ-018 BUSY, neither transfer: hold.
REQ-019 FULL: on output transfer, main<=skid and go to BUSY; otherwise hold. Input is never accepted in FULL.
REQ-020 Latency SHALL be 1 cycle: a word accepted at edge N appears on out_data with out_valid=1 after edge N when the block was EMPTY.
REQ-021 Ordering SHALL be strict FIFO; no word is dropped, duplicated or reordered.
REQ-022 out_data and out_valid SHALL stay stable while out_valid=1 and out_ready=0.
REQ-023 flush=1 at an edge SHALL force EMPTY and override every transfer on that edge, so accepted-in-same-cycle words are discarded. main and skid SHALL keep their contents.
REQ-024 Throughput SHALL be one word per cycle while out_ready=1 is held continuously.

Reset
REQ-025 rst=1 SHALL immediately, without waiting for clk, force state EMPTY, main=0, skid=0, out_valid=0, out_data=0 and in_ready=1.
REQ-026 rst asserted mid-transfer SHALL lose all held words; the first edge after rst deasserts SHALL behave as EMPTY.

Configuration
REQ-027 Macro SKID_REG16_INVERT_EN, when defined, SHALL make out_data the bitwise inversion of main. After reset out_data SHALL then read all-ones (16'hFFFF). Handshake and timing SHALL be unchanged.
REQ-028 Without SKID_REG16_INVERT_EN, out_data SHALL equal main unmodified.

Verification
REQ-029 Single word: reset, then in_data=16'h1234, in_valid=1 for one edge, out_ready=1 -> next cycle out_valid=1, out_data=16'h1234; one edge later out_valid=0.
REQ-030 Backpressure: out_ready=0, push 16'hA5A5 then 16'h5A5A -> in_ready=0 after the second accept and out_data=16'hA5A5 stays stable. Then out_ready=1 -> A5A5, then 5A5A, then out_valid=0, and in_ready=1 again after the first drain.
REQ-031 Streaming: in_valid=1 and out_ready=1 held, in_data counting 0..99 -> out_data 0..99 on consecutive cycles with no bubbles after the first-cycle latency.
REQ-032 Flush: in FULL (holding 16'h0001 and 16'h0002), assert flush with in_valid=1 -> next cycle out_valid=0, in_ready=1, and no further output appears.
REQ-033 Async reset: in FULL, pulse rst between clock edges -> out_valid=0 and out_data=0 immediately, or 16'hFFFF with SKID_REG16_INVERT_EN.
REQ-034 Inversion: with SKID_REG16_INVERT_EN, push 16'h00FF -> out_data=16'hFF00.
